// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: default bus widths and FSM states.
package data_memory_arbiter_pkg;

    localparam int DEF_ADDR_W = 48;
    localparam int DEF_DATA_W = 64;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Requester-side handshake bundle and memory-side bus bundle for the data-memory arbiter.
interface data_memory_arbiter_if #(
    parameter int ADDR_W = data_memory_arbiter_pkg::DEF_ADDR_W,
    parameter int DATA_W = data_memory_arbiter_pkg::DEF_DATA_W
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rvalid, rdata);
endinterface

interface data_memory_bus_if #(
    parameter int ADDR_W = data_memory_arbiter_pkg::DEF_ADDR_W,
    parameter int DATA_W = data_memory_arbiter_pkg::DEF_DATA_W
) ();
    logic              mem_write;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    modport master (output mem_write, mem_read, mem_address, mem_write_data, input mem_read_data);
    modport slave  (input mem_write, mem_read, mem_address, mem_write_data, output mem_read_data);
endinterface

// File: rtl/data_memory_arbiter_rr_arbiter2.sv
// Two-way grant logic: single requester wins, ties go to the port other than last_grant
// unless fixed priority is selected, in which case port 0 always wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       fixed,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req[0] && req[1]) begin
            gnt = (fixed || last_grant) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single-port data memory between two requesters, sequencing each access
// through IDLE -> ISSUE (-> WAIT) and returning read data with a one-cycle valid pulse.
module data_memory_arbiter #(
    parameter int ADDR_W         = data_memory_arbiter_pkg::DEF_ADDR_W,
    parameter int DATA_W         = data_memory_arbiter_pkg::DEF_DATA_W,
    parameter int READ_LATENCY   = 1,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    data_memory_arbiter_if.slave p0,
    data_memory_arbiter_if.slave p1,
    data_memory_bus_if.master    mem
);
    import data_memory_arbiter_pkg::*;

    localparam int               CNT_W  = $clog2(READ_LATENCY) + 1;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(READ_LATENCY - 1);

    state_t            state;
    logic              last_grant;
    logic              owner;
    logic              we_q;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        ack_q;
    logic [1:0]        rvalid_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              mem_write_q;
    logic              mem_read_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign req = {p1.req, p0.req};

    rr_arbiter2 u_arb (
        .req        (req),
        .last_grant (last_grant),
        .fixed      (FIXED_PRIORITY != 0),
        .gnt        (gnt)
    );

    always_comb begin
        sel_we    = p0.we;
        sel_addr  = p0.addr;
        sel_wdata = p0.wdata;
        if (gnt[1]) begin
            sel_we    = p1.we;
            sel_addr  = p1.addr;
            sel_wdata = p1.wdata;
        end
    end

    // The memory-facing address/data registers double as the latched request,
    // so they are loaded on the IDLE->ISSUE edge and cleared on return to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            we_q        <= 1'b0;
            cnt         <= '0;
            ack_q       <= '0;
            rvalid_q    <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            ack_q       <= '0;
            rvalid_q    <= '0;
            mem_write_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        owner       <= gnt[1];
                        last_grant  <= gnt[1];
                        we_q        <= sel_we;
                        ack_q       <= gnt;
                        mem_write_q <= sel_we;
                        mem_read_q  <= ~sel_we;
                        addr_q      <= sel_addr;
                        wdata_q     <= sel_wdata;
                        cnt         <= LAT_M1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    if (!we_q && cnt != '0) begin
                        cnt   <= cnt - CNT_W'(1);
                        state <= S_WAIT;
                    end else begin
                        if (!we_q) begin
                            if (owner) rdata1_q <= mem.mem_read_data;
                            else       rdata0_q <= mem.mem_read_data;
                            rvalid_q <= owner ? 2'b10 : 2'b01;
                        end
                        mem_read_q <= 1'b0;
                        addr_q     <= '0;
                        wdata_q    <= '0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign p0.ack    = ack_q[0];
    assign p1.ack    = ack_q[1];
    assign p0.rvalid = rvalid_q[0];
    assign p1.rvalid = rvalid_q[1];
    assign p0.rdata  = rdata0_q;
    assign p1.rdata  = rdata1_q;

    assign mem.mem_write      = mem_write_q;
    assign mem.mem_read       = mem_read_q;
    assign mem.mem_address    = addr_q;
    assign mem.mem_write_data = wdata_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench: a round-robin arbiter behind a pipelined memory model, plus a
// fixed-priority instance for the starvation ordering.
`timescale 1ns/1ps
module tb_data_memory_arbiter;

    localparam int AW  = 48;
    localparam int DW  = 64;
    localparam int LAT = 3;

    typedef struct {
        int            port;
        bit            is_ack;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_q = 1'b1;
    logic mem_clr = 1'b1;
    always #5 clk = ~clk;
    always @(posedge clk) rst_q <= rst;

    data_memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p0_if ();
    data_memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p1_if ();
    data_memory_bus_if     #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();
    data_memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) q0_if ();
    data_memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) q1_if ();
    data_memory_bus_if     #(.ADDR_W(AW), .DATA_W(DW)) m2_if ();

    data_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(LAT), .FIXED_PRIORITY(0)) dut (
        .clk(clk), .rst(rst), .p0(p0_if), .p1(p1_if), .mem(mem_if));

    data_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1), .FIXED_PRIORITY(1)) dut_fixed (
        .clk(clk), .rst(rst), .p0(q0_if), .p1(q1_if), .mem(m2_if));

    // requester drive for the round-robin instance
    logic          req_d   [2];
    logic          we_d    [2];
    logic [AW-1:0] addr_d  [2];
    logic [DW-1:0] wdata_d [2];
    logic          ack_s   [2];
    logic          rvalid_s[2];
    logic [DW-1:0] rdata_s [2];
    assign p0_if.req = req_d[0];   assign p1_if.req = req_d[1];
    assign p0_if.we = we_d[0];     assign p1_if.we = we_d[1];
    assign p0_if.addr = addr_d[0]; assign p1_if.addr = addr_d[1];
    assign p0_if.wdata = wdata_d[0]; assign p1_if.wdata = wdata_d[1];
    assign ack_s[0] = p0_if.ack;   assign ack_s[1] = p1_if.ack;
    assign rvalid_s[0] = p0_if.rvalid; assign rvalid_s[1] = p1_if.rvalid;
    assign rdata_s[0] = p0_if.rdata;   assign rdata_s[1] = p1_if.rdata;

    // fixed-priority instance drive
    logic          q_req [2];
    logic [AW-1:0] q_addr[2];
    logic [DW-1:0] q_data[2];
    assign q0_if.req = q_req[0];  assign q1_if.req = q_req[1];
    assign q0_if.we = 1'b1;       assign q1_if.we = 1'b1;
    assign q0_if.addr = q_addr[0]; assign q1_if.addr = q_addr[1];
    assign q0_if.wdata = q_data[0]; assign q1_if.wdata = q_data[1];
    assign m2_if.mem_read_data = '0;

    // data_memory model: read data appears LAT-1 cycles after the address is presented
    logic [DW-1:0] mem_arr [256];
    logic [DW-1:0] pipe [LAT-1];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= '0;
        end else if (mem_if.mem_write) begin
            mem_arr[mem_if.mem_address[7:0]] <= mem_if.mem_write_data;
        end
        pipe[0] <= mem_arr[mem_if.mem_address[7:0]];
        for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_if.mem_read_data = pipe[LAT-2];

    // scoreboard state
    ev_t           exp_q[$];
    int            exp2_q[$];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    bit            mon_en = 1'b0;
    bit            prev_mw = 1'b0;
    int            last_ack_cyc = -1000;
    int            min_gap = 0;
    logic [DW-1:0] exp_rdata [2];

    // reference model: flat memory image plus the last winner
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    int            ref_last = 1;

    function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    function automatic void predict(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ev_t e;
        e.port = p; e.is_ack = 1'b1; e.we = we; e.addr = a; e.data = we ? d : '0;
        exp_q.push_back(e);
        if (we) begin
            ref_mem[a] = d;
        end else begin
            e.is_ack = 1'b0;
            e.data = ref_rd(a);
            exp_q.push_back(e);
        end
        ref_last = p;
    endfunction

    function automatic void check_ev(input int p, input bit is_ack);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_event: port %0d %s, required none (cycle %0d)", p, is_ack ? "ack" : "rvalid", cyc);
            return;
        end
        e = exp_q.pop_front();
        chk("event_port", DW'(p), DW'(e.port));
        chk("event_kind", DW'(is_ack), DW'(e.is_ack));
        if (is_ack) begin
            chk("ack_spacing_ok", DW'(cyc - last_ack_cyc >= min_gap), 1);
            chk("issue_addr", mem_if.mem_address, e.addr);
            chk("issue_we", mem_if.mem_write, e.we);
            chk("issue_rd", mem_if.mem_read, !e.we);
            if (e.we) chk("issue_wdata", mem_if.mem_write_data, e.data);
            last_ack_cyc = cyc;
            min_gap = e.we ? 2 : LAT + 1;
        end else begin
            chk("rvalid_latency", DW'(cyc - last_ack_cyc), LAT);
            chk("rdata", rdata_s[p], e.data);
            exp_rdata[p] = e.data;
        end
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (rst_q) begin
                last_ack_cyc = -1000;
                exp_rdata[0] = '0;
                exp_rdata[1] = '0;
            end
            if (mem_if.mem_write || mem_if.mem_read) begin
                chk("mem_exclusive", mem_if.mem_write & mem_if.mem_read, 0);
            end else begin
                chk("idle_addr", mem_if.mem_address, 0);
                chk("idle_wdata", mem_if.mem_write_data, 0);
            end
            if (mem_if.mem_write) chk("mem_write_single_cycle", prev_mw, 0);
            prev_mw = mem_if.mem_write;
            for (int p = 0; p < 2; p++) begin
                if (ack_s[p]) check_ev(p, 1'b1);
                if (rvalid_s[p]) check_ev(p, 1'b0);
                else chk(p == 0 ? "p0_rdata_hold" : "p1_rdata_hold", rdata_s[p], exp_rdata[p]);
            end
            if (q0_if.ack || q1_if.ack) begin
                if (exp2_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL fixed_unexpected_ack: got ack, required none (cycle %0d)", cyc);
                end else begin
                    chk("fixed_ack_port", DW'(q1_if.ack), DW'(exp2_q.pop_front()));
                end
            end
        end
    end

    a_p0_hold: assert property (@(posedge clk) disable iff (rst)
        (p0_if.req && !p0_if.ack) |=> (p0_if.req || p0_if.ack))
        else begin failures++; $display("FAIL p0_req_hold: got req dropped before ack, required held"); end
    a_p1_hold: assert property (@(posedge clk) disable iff (rst)
        (p1_if.req && !p1_if.ack) |=> (p1_if.req || p1_if.ack))
        else begin failures++; $display("FAIL p1_req_hold: got req dropped before ack, required held"); end

    // caller is positioned at a negedge; returns at the negedge of the final response
    task automatic port_txn(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output int ack_k);
        int k;
        req_d[p] = 1'b1; we_d[p] = we; addr_d[p] = a; wdata_d[p] = d;
        k = 0;
        do begin @(negedge clk); k++; end while (!ack_s[p] && k < 60);
        ack_k = k;
        req_d[p] = 1'b0; we_d[p] = 1'b0; addr_d[p] = '0; wdata_d[p] = '0;
        checks++;
        if (!ack_s[p]) begin
            failures++;
            $display("FAIL ack_timeout: port %0d got no ack, required ack within 60 cycles", p);
        end else if (!we) begin
            k = 0;
            do begin @(negedge clk); k++; end while (!rvalid_s[p] && k < 20);
            checks++;
            if (!rvalid_s[p]) begin
                failures++;
                $display("FAIL rvalid_timeout: port %0d got no rvalid, required rvalid within 20 cycles", p);
            end
        end
    endtask

    task automatic round(input bit r0, input bit r1, input bit we0, input bit we1,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        int first, k0, k1;
        first = (r0 && r1) ? ((ref_last == 0) ? 1 : 0) : (r0 ? 0 : 1);
        if (first == 0) begin
            predict(0, we0, a0, d0);
            if (r1) predict(1, we1, a1, d1);
        end else begin
            predict(1, we1, a1, d1);
            if (r0) predict(0, we0, a0, d0);
        end
        fork
            if (r0) port_txn(0, we0, a0, d0, k0);
            if (r1) port_txn(1, we1, a1, d1, k1);
        join
    endtask

    initial begin
        int k, r;
        ev_t e;
        logic [AW-1:0] a;
        for (int p = 0; p < 2; p++) begin
            req_d[p] = 1'b0; we_d[p] = 1'b0; addr_d[p] = '0; wdata_d[p] = '0;
            q_req[p] = 1'b0; q_addr[p] = '0; q_data[p] = '0;
        end

        // reset held with both requests pending
        req_d[0] = 1'b1; we_d[0] = 1'b1; addr_d[0] = 48'h10; wdata_d[0] = 64'hA0;
        req_d[1] = 1'b1; we_d[1] = 1'b1; addr_d[1] = 48'h18; wdata_d[1] = 64'hA1;
        repeat (3) begin
            @(negedge clk);
            mon_en = 1'b1;
            chk("rst_p0_ack", ack_s[0], 0);
            chk("rst_p1_ack", ack_s[1], 0);
            chk("rst_mem_write", mem_if.mem_write, 0);
            chk("rst_mem_read", mem_if.mem_read, 0);
            chk("rst_p0_rvalid", rvalid_s[0], 0);
            chk("rst_p0_rdata", rdata_s[0], 0);
        end
        rst = 1'b0; mem_clr = 1'b0; ref_last = 1;
        round(1, 1, 1, 1, 48'h10, 48'h18, 64'hA0, 64'hA1);

        // single write then read on p0
        repeat (3) @(negedge clk);
        predict(0, 1'b1, 48'h28, 64'h11);
        port_txn(0, 1'b1, 48'h28, 64'h11, k);
        chk("write_ack_latency", DW'(k), 1);
        repeat (3) @(negedge clk);
        predict(0, 1'b0, 48'h28, '0);
        port_txn(0, 1'b0, 48'h28, '0, k);
        chk("read_ack_latency", DW'(k), 1);

        // cross-port read
        round(0, 1, 0, 1, '0, 48'h50, '0, 64'hDEAD);
        round(1, 0, 0, 0, 48'h50, '0, '0, '0);

        // round-robin contention: p1 goes first to leave last_grant at p1
        round(0, 1, 0, 1, '0, 48'h60, '0, 64'h77);
        round(1, 1, 1, 1, 48'h30, 48'h38, 64'h1, 64'h2);
        round(1, 1, 1, 1, 48'h30, 48'h38, 64'h3, 64'h4);

        // back-to-back writes then reads on p0
        for (int i = 0; i < 16; i++) round(1, 0, 1, 0, AW'(i * 5), '0, DW'(i + 1), '0);
        for (int i = 0; i < 16; i++) round(1, 0, 0, 0, AW'(i * 5), '0, '0, '0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(1, 3);
            round(r[0], r[1], 1'($urandom), 1'($urandom),
                  AW'($urandom_range(0, 31) * 4), AW'($urandom_range(0, 31) * 4),
                  {$urandom, $urandom}, {$urandom, $urandom});
        end

        // reset while the read is in WAIT: its response must never appear
        repeat (LAT + 2) @(negedge clk);
        a = 48'h50;
        e.port = 0; e.is_ack = 1'b1; e.we = 1'b0; e.addr = a; e.data = '0;
        exp_q.push_back(e);
        req_d[0] = 1'b1; we_d[0] = 1'b0; addr_d[0] = a;
        k = 0;
        do begin @(negedge clk); k++; end while (!ack_s[0] && k < 20);
        req_d[0] = 1'b0; addr_d[0] = '0;
        chk("abort_read_acked", ack_s[0], 1);
        @(negedge clk);
        rst = 1'b1; ref_last = 1;
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        round(1, 1, 0, 1, 48'h50, 48'h58, '0, 64'h5A);

        // fixed-priority instance: p1 held throughout, p0 replaces its request after each ack
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) exp2_q.push_back(0);
        q_req[1] = 1'b1; q_addr[1] = 48'h8; q_data[1] = 64'hBB;
        q_req[0] = 1'b1; q_addr[0] = 48'h0; q_data[0] = 64'h100;
        for (int i = 0; i < 4; i++) begin
            k = 0;
            do begin @(negedge clk); k++; end while (!q0_if.ack && k < 20);
            chk("fixed_p0_acked", q0_if.ack, 1);
            if (i < 3) begin
                q_addr[0] = AW'(i + 1); q_data[0] = DW'(256 + i + 1);
            end else begin
                q_req[0] = 1'b0; q_req[1] = 1'b0;
            end
        end

        repeat (8) @(negedge clk);
        chk("scoreboard_drained", DW'(exp_q.size()), 0);
        chk("fixed_scoreboard_drained", DW'(exp2_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish within 200000 ns");
        $fatal(1, "watchdog");
    end

endmodule
